lsu_byte_serial: RTL

Memory-side consumer of the decode stage's access-size codes (one-hot 001 byte, 010 half, 100 word; 000 no access). Takes one load/store request from the memory stage and performs it as a little-endian, byte-serial sequence on a byte-wide synchronous data RAM. For loads it assembles the bytes, then sign- or zero-extends the result. It stalls the pipeline while the access is in flight.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_load_extend.sv | 26 ++
 rtl/lsu_byte_serial.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size codes, FSM state type and size decode for the byte-serial LSU
package lsu_pkg;

  localparam logic [2:0] SIZE_NONE = 3'b000;
  localparam logic [2:0] SIZE_BYTE = 3'b001;
  localparam logic [2:0] SIZE_HALF = 3'b010;
  localparam logic [2:0] SIZE_WORD = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // Malformed non-zero codes fall back to a full word access.
  function automatic logic [2:0] size_to_count(input logic [2:0] size);
    logic [2:0] n;
    case (size)
      SIZE_NONE: n = 3'd0;
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      default:   n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - sign/zero extension of an assembled little-endian load value
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  logic w_sign_b;
  logic w_sign_h;

  assign w_sign_b = i_data[7]  & ~i_unsigned;
  assign w_sign_h = i_data[15] & ~i_unsigned;

  always_comb begin
    o_data = i_data;
    case (i_size)
      SIZE_BYTE: o_data = {{24{w_sign_b}}, i_data[7:0]};
      SIZE_HALF: o_data = {{16{w_sign_h}}, i_data[15:0]};
      default:   o_data = i_data;
    endcase
  end

endmodule

// File: rtl/lsu_byte_serial.sv
// rtl/lsu_byte_serial.sv - load/store unit that serialises word/half/byte accesses onto a byte-wide RAM
module lsu_byte_serial
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  is_store_i,
  input  logic [2:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rdata_o,
  output logic                  stall_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [7:0]            mem_wdata_o,
  input  logic [7:0]            mem_rdata_i
);

  lsu_state_t            r_state;
  logic                  r_is_store;
  logic [2:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_wdata;
  logic [1:0]            r_k;
  logic [1:0]            r_last;
  logic                  r_cap_en;
  logic [1:0]            r_cap_idx;
  logic [31:0]           r_asm;
  logic                  r_rsp_valid;
  logic [31:0]           r_rdata;

  logic [2:0]            w_n;
  logic                  w_in_access;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_wbyte;
  logic [31:0]           w_asm;
  logic [31:0]           w_ext;

  assign w_n         = size_to_count(size_i);
  assign w_in_access = (r_state == ACCESS);
  assign w_addr      = r_base + {{(ADDR_WIDTH-2){1'b0}}, r_k};
  assign w_wbyte     = r_wdata[{r_k, 3'b000} +: 8];

  // Read data lags its address by one cycle, so byte k lands one cycle after ACCESS k.
  always_comb begin
    w_asm = r_asm;
    if (r_cap_en) begin
      w_asm[{r_cap_idx, 3'b000} +: 8] = mem_rdata_i;
    end
  end

  lsu_load_extend u_extend (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_data     (w_asm),
    .o_data     (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_is_store  <= 1'b0;
      r_size      <= SIZE_NONE;
      r_unsigned  <= 1'b0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_k         <= '0;
      r_last      <= '0;
      r_cap_en    <= 1'b0;
      r_cap_idx   <= '0;
      r_asm       <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_cap_en    <= 1'b0;
      r_asm       <= w_asm;
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_is_store <= is_store_i;
            r_size     <= size_i;
            r_unsigned <= unsigned_i;
            r_base     <= addr_i[ADDR_WIDTH-1:0];
            r_wdata    <= wdata_i;
            r_k        <= '0;
            r_last     <= w_n[1:0] - 2'd1;
            r_asm      <= '0;
            if (w_n == 3'd0) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rdata     <= '0;
            end else begin
              r_state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!r_is_store) begin
            r_cap_en  <= 1'b1;
            r_cap_idx <= r_k;
          end
          if (r_k == r_last) begin
            if (r_is_store) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rdata     <= '0;
            end else begin
              r_state <= WAIT;
            end
          end else begin
            r_k <= r_k + 2'd1;
          end
        end
        WAIT: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rdata     <= w_ext;
        end
        RESP: begin
          r_state <= IDLE;
          r_rdata <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (r_state == IDLE);
  assign stall_o     = ((r_state == IDLE) && req_valid_i) || w_in_access || (r_state == WAIT);
  assign rsp_valid_o = r_rsp_valid;
  assign rdata_o     = r_rdata;

  // Gating with rst keeps an aborted store from writing the byte of the reset cycle.
  assign mem_we_o    = w_in_access && r_is_store && !rst;
  assign mem_addr_o  = w_in_access ? w_addr : '0;
  assign mem_wdata_o = (w_in_access && r_is_store) ? w_wbyte : 8'h00;

endmodule
